// File: rtl/tx_shaping_filter.sv
// tx_shaping_filter: polyphase FIR pulse shaper, OS samples per 2-bit mapped symbol.
// Optional sticky underrun flag enabled by defining TX_SHAPING_FILTER_UNDERRUN_EN.
`default_nettype none

module tx_shaping_filter #(
  parameter int                          OS     = 4,
  parameter int                          NBAUD  = 6,
  parameter int                          COEF_W = 8,
  parameter logic [OS*NBAUD*COEF_W-1:0]  COEFS  = '0,
  parameter int                          OUT_W  = COEF_W + 2 + $clog2(NBAUD)
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_valid,
  input  logic [1:0]              i_symbol,
  output logic signed [OUT_W-1:0] o_sample,
  output logic                    o_valid
`ifdef TX_SHAPING_FILTER_UNDERRUN_EN
  ,
  output logic                    o_underrun
`endif
);

  localparam int PH_W = (OS > 1) ? $clog2(OS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);

  logic [NBAUD-1:0][1:0]   sym_q, sym_d;
  logic [PH_W-1:0]         ph_q, ph_d;
  logic signed [OUT_W-1:0] sample_q, sample_d;
  logic                    valid_q;

  // A strobe restarts the phase even when it arrives early; otherwise the
  // phase free-runs and wraps, holding the delay line.
  always_comb begin
    sym_d = sym_q;
    ph_d  = ph_q + PH_W'(1);
    if (i_valid) begin
      sym_d = {sym_q[NBAUD-2:0], i_symbol};
      ph_d  = '0;
    end
  end

  always_comb begin
    int idx;
    idx      = 0;
    sample_d = '0;
    for (int k = 0; k < NBAUD; k++) begin
      idx      = (k * OS + int'(ph_q)) * COEF_W;
      sample_d = sample_d
               + OUT_W'($signed(sym_q[k])) * OUT_W'($signed(COEFS[idx +: COEF_W]));
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      sym_q    <= '0;
      ph_q     <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else if (i_enable) begin
      sym_q    <= sym_d;
      ph_q     <= ph_d;
      sample_q <= sample_d;
      valid_q  <= 1'b1;
    end else begin
      valid_q  <= 1'b0;
    end
  end

  assign o_sample = sample_q;
  assign o_valid  = valid_q;

`ifdef TX_SHAPING_FILTER_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      underrun_q <= 1'b0;
    end else if (i_enable && (ph_q == PH_LAST) && !i_valid) begin
      underrun_q <= 1'b1;
    end
  end

  assign o_underrun = underrun_q;
`else
  // Without the flag a missing strobe is absorbed by the silent phase wrap.
  logic unused_ph_last;
  assign unused_ph_last = ^PH_LAST;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_shaping_filter.sv
// tb_tx_shaping_filter: vector table, directed corner sequences and a
// randomized run against an integer reference model of the shaping filter.
`default_nettype none

module tb_tx_shaping_filter;

  localparam int OS     = 4;
  localparam int NBAUD  = 6;
  localparam int COEF_W = 8;
  localparam int NTAPS  = OS * NBAUD;
  localparam int OUT_W  = 13;

  function automatic logic [NTAPS*COEF_W-1:0] make_coefs();
    logic [NTAPS*COEF_W-1:0] v;
    v = '0;
    for (int i = 0; i < NTAPS; i++) v[i*COEF_W +: COEF_W] = COEF_W'(i + 1);
    return v;
  endfunction

  localparam logic [NTAPS*COEF_W-1:0] TB_COEFS = make_coefs();

  logic                    clock = 1'b0;
  logic                    i_reset;
  logic                    i_enable;
  logic                    i_valid;
  logic [1:0]              i_symbol;
  logic signed [OUT_W-1:0] o_sample;
  logic                    o_valid;
`ifdef TX_SHAPING_FILTER_UNDERRUN_EN
  logic                    o_underrun;
`endif

  tx_shaping_filter #(
    .OS(OS), .NBAUD(NBAUD), .COEF_W(COEF_W), .COEFS(TB_COEFS), .OUT_W(OUT_W)
  ) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_valid  (i_valid),
    .i_symbol (i_symbol),
    .o_sample (o_sample),
    .o_valid  (o_valid)
`ifdef TX_SHAPING_FILTER_UNDERRUN_EN
    ,
    .o_underrun (o_underrun)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers, symbol history and a phase index.
  int msym[NBAUD];
  int mph;
  int mout;
  bit mval;
  bit mund;

  function automatic int sym_value(input logic [1:0] s);
    case (s)
      2'b01:   return 1;
      2'b11:   return -1;
      2'b10:   return -2;
      default: return 0;
    endcase
  endfunction

  function automatic int coef(input int i);
    return i + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NBAUD; k++) msym[k] = 0;
    mph = 0; mout = 0; mval = 0; mund = 0;
  endtask

  task automatic model_step(input bit en, input bit val, input logic [1:0] s);
    int acc;
    if (!en) begin
      mval = 0;
      return;
    end
    acc = 0;
    for (int k = 0; k < NBAUD; k++) acc += msym[k] * coef(k * OS + mph);
    mout = acc;
    mval = 1;
    if (mph == OS - 1 && !val) mund = 1;
    if (val) begin
      for (int k = NBAUD - 1; k > 0; k--) msym[k] = msym[k-1];
      msym[0] = sym_value(s);
      mph = 0;
    end else begin
      mph = (mph + 1) % OS;
    end
  endtask

  // Drive inputs, advance one edge, and leave time at edge+1 for sampling.
  task automatic step(input bit en, input bit val, input logic [1:0] s);
    i_enable = en; i_valid = val; i_symbol = s;
    model_step(en, val, s);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #2;
    i_reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit         en;
    bit         val;
    logic [1:0] sym;
    int         exp_s;
    bit         exp_v;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   cnt;

    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_symbol = 2'b00;
    model_reset();
    @(posedge clock); #1;
    chk("reset_sample", int'(o_sample), 0);
    chk("reset_valid", int'(o_valid), 0);
`ifdef TX_SHAPING_FILTER_UNDERRUN_EN
    chk("reset_underrun", int'(o_underrun), 0);
`endif
    do_reset();

    // Impulse with a three-cycle enable gap; strobes during the gap must be ignored.
    for (int c = 0; c < 30; c++) begin
      if (c == 10) begin
        for (int g = 0; g < 3; g++) begin
          v = '{en: 1'b0, val: 1'b1, sym: 2'b01, exp_s: 9, exp_v: 1'b0};
          tbl.push_back(v);
        end
      end
      v.en    = 1'b1;
      v.val   = (c % 4 == 0);
      v.sym   = (c == 0) ? 2'b01 : 2'b00;
      v.exp_s = (c >= 1 && c <= 24) ? c : 0;
      v.exp_v = 1'b1;
      tbl.push_back(v);
    end
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].val, tbl[i].sym);
      chk($sformatf("impulse_sample[%0d]", i), int'(o_sample), tbl[i].exp_s);
      chk($sformatf("impulse_valid[%0d]", i), int'(o_valid), int'(tbl[i].exp_v));
    end

    // All -1 then full-scale -2: six strobes fill the line, next four phases checked.
    do_reset();
    for (int c = 0; c < 21; c++) step(1'b1, c % 4 == 0, 2'b11);
    for (int p = 0; p < OS; p++) begin
      step(1'b1, p == OS - 1, 2'b11);
      chk($sformatf("all_m1_ph%0d", p), int'(o_sample), -(66 + 6 * p));
    end
    do_reset();
    for (int c = 0; c < 21; c++) step(1'b1, c % 4 == 0, 2'b10);
    for (int p = 0; p < OS; p++) begin
      step(1'b1, p == OS - 1, 2'b10);
      chk($sformatf("all_m2_ph%0d", p), int'(o_sample), -2 * (66 + 6 * p));
    end

    // Early strobe restarts the phase; then an asynchronous reset mid-run.
    do_reset();
    step(1'b1, 1'b1, 2'b01);
    step(1'b1, 1'b0, 2'b00);
    chk("early_pre1", int'(o_sample), 1);
    step(1'b1, 1'b1, 2'b00);
    chk("early_pre2", int'(o_sample), 2);
    step(1'b1, 1'b0, 2'b00);
    chk("early_ph0", int'(o_sample), 5);
    step(1'b1, 1'b0, 2'b00);
    chk("early_ph1", int'(o_sample), 6);
    i_reset = 1'b1;
    #1;
    chk("async_rst_sample", int'(o_sample), 0);
    chk("async_rst_valid", int'(o_valid), 0);
    #1;
    i_reset = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 2'b00);
    chk("post_rst_valid", int'(o_valid), 1);
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0, 2'b00);
      chk($sformatf("post_rst_cleared[%0d]", c), int'(o_sample), 0);
    end

`ifdef TX_SHAPING_FILTER_UNDERRUN_EN
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(1'b1, c == 0, 2'b01);
      chk($sformatf("underrun_low[%0d]", c), int'(o_underrun), 0);
    end
    step(1'b1, 1'b0, 2'b00);
    chk("underrun_rise", int'(o_underrun), 1);
    for (int c = 0; c < 8; c++) step(1'b1, c % 4 == 0, 2'b01);
    chk("underrun_sticky", int'(o_underrun), 1);
`endif

    // Randomized run against the reference model.
    do_reset();
    cnt = 0;
    for (int c = 0; c < 800; c++) begin
      bit         en;
      bit         val;
      logic [1:0] s;
      en  = ($urandom_range(9) != 0);
      val = (cnt == OS - 1) ? ($urandom_range(19) != 0) : ($urandom_range(9) == 0);
      s   = 2'($urandom);
      step(en, val, s);
      if (en) cnt = val ? 0 : (cnt + 1) % OS;
      chk("rand_sample", int'(o_sample), mout);
      chk("rand_valid", int'(o_valid), int'(mval));
`ifdef TX_SHAPING_FILTER_UNDERRUN_EN
      chk("rand_underrun", int'(o_underrun), int'(mund));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
